// File: rtl/ps_mm_buf_scheduler.sv
// ps_mm_buf_scheduler
//
// Buffer-ring scheduler that sits in front of ps_mm_writer. Each packet from the
// PacketStream source gets one of BUFCOUNT fixed-size buffers. The scheduler drives the
// writer's start address for that buffer. Packets longer than BUFWORDS words are cut at
// the buffer boundary, and the rest of the packet is discarded. Every stored packet is
// reported as a descriptor. A buffer stays held until the consumer pulses f_req, and
// buffers are released oldest first.
//
// Ports
//   reset, clk                    async active-high reset, clock
//   i_dat/i_mty/i_val/i_eop/i_rdy upstream PacketStream (i_mty valid with i_eop)
//   o_dat/o_mty/o_val/o_eop/o_rdy stream toward the writer (zero-latency pass-through)
//   o_addr                        writer start address, BASE + wr_idx*BUFWORDS
//   d_idx/d_len/d_mty/d_err       descriptor: buffer, words written, last mty, truncated
//   d_val/d_rdy                   descriptor handshake
//   f_req                         release the oldest held buffer (1-cycle pulse)
//   used                          number of buffers currently held
module ps_mm_buf_scheduler #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 8,
  parameter int SYMBOLS  = 4,
  parameter int BASE     = 0,
  parameter int BUFWORDS = 16,
  parameter int BUFCOUNT = 4
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic [DWIDTH-1:0]             i_dat,
  input  logic [$clog2(SYMBOLS)-1:0]    i_mty,
  input  logic                          i_val,
  input  logic                          i_eop,
  output logic                          i_rdy,
  output logic [DWIDTH-1:0]             o_dat,
  output logic [$clog2(SYMBOLS)-1:0]    o_mty,
  output logic                          o_val,
  output logic                          o_eop,
  input  logic                          o_rdy,
  output logic [AWIDTH-1:0]             o_addr,
  output logic [$clog2(BUFCOUNT)-1:0]   d_idx,
  output logic [$clog2(BUFWORDS):0]     d_len,
  output logic [$clog2(SYMBOLS)-1:0]    d_mty,
  output logic                          d_err,
  output logic                          d_val,
  input  logic                          d_rdy,
  input  logic                          f_req,
  output logic [$clog2(BUFCOUNT):0]     used
);

  localparam int MW     = $clog2(SYMBOLS);
  localparam int IW     = $clog2(BUFCOUNT);
  localparam int LW     = $clog2(BUFWORDS) + 1;
  localparam int UW     = $clog2(BUFCOUNT) + 1;
  localparam int BW_LOG = $clog2(BUFWORDS);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] wr_idx_nxt;
  logic [LW-1:0] count;
  logic [LW-1:0] len_now;
  logic          open;
  logic          last_slot;
  logic          trunc;
  logic          acc;
  logic          desc_wr;
  logic          rel;

  function automatic logic [AWIDTH-1:0] addr_of(input logic [IW-1:0] idx);
    return AWIDTH'(BASE) + (AWIDTH'(idx) << BW_LOG);
  endfunction

  assign o_dat = i_dat;

  // NOTE: every signal written in this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    open      = (state == IDLE) && (used < UW'(BUFCOUNT)) && !d_val;
    // The word arriving now fills the last slot of the buffer.
    last_slot = (state == IDLE) ? (BUFWORDS == 1) : (count == LW'(BUFWORDS - 1));
    i_rdy     = 1'b0;
    o_val     = 1'b0;
    case (state)
      IDLE: begin
        i_rdy = open & o_rdy;
        o_val = open & i_val;
      end
      PASS: begin
        i_rdy = o_rdy;
        o_val = i_val;
      end
      DROP: i_rdy = 1'b1;
      default: ;
    endcase
    // A non-eop word in the last slot ends the packet toward the writer.
    trunc   = (state != DROP) && last_slot && !i_eop;
    o_eop   = i_eop | trunc;
    o_mty   = trunc ? '0 : i_mty;
    acc     = i_val & i_rdy;
    desc_wr = acc && (state != DROP) && (i_eop || last_slot);
    len_now = (state == IDLE) ? LW'(1) : count + LW'(1);
    rel     = f_req && (used != '0);

    wr_idx_nxt = desc_wr ? wr_idx + IW'(1) : wr_idx;

    state_nxt = state;
    case (state)
      IDLE: if (acc && !i_eop) state_nxt = last_slot ? DROP : PASS;
      PASS: if (acc) begin
        if (i_eop)          state_nxt = IDLE;
        else if (last_slot) state_nxt = DROP;
      end
      DROP: if (acc && i_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_idx <= '0;
      count  <= '0;
      used   <= '0;
      d_idx  <= '0;
      d_len  <= '0;
      d_mty  <= '0;
      d_err  <= 1'b0;
      d_val  <= 1'b0;
      o_addr <= AWIDTH'(BASE);
    end else begin
      state  <= state_nxt;
      wr_idx <= wr_idx_nxt;

      if (acc && state != DROP) count <= len_now;

      if (desc_wr) begin
        d_idx <= wr_idx;
        d_len <= len_now;
        d_mty <= i_eop ? i_mty : MW'(0);
        d_err <= !i_eop;
        d_val <= 1'b1;
      end else if (d_rdy) begin
        d_val <= 1'b0;
      end

      // An allocation and a release on the same edge cancel out.
      if (desc_wr && !rel)      used <= used + UW'(1);
      else if (rel && !desc_wr) used <= used - UW'(1);

      // Track the next buffer only across packet boundaries, so the address seen by
      // the writer never moves inside a packet.
      if (state_nxt == IDLE) o_addr <= addr_of(wr_idx_nxt);
    end
  end

endmodule

// File: tb/tb_ps_mm_buf_scheduler.sv
// Directed bench for ps_mm_buf_scheduler with default parameters
// (BASE=0, BUFWORDS=16, BUFCOUNT=4, SYMBOLS=4).
module tb_ps_mm_buf_scheduler;

  logic       reset = 1'b1;
  logic       clk   = 1'b0;
  logic [7:0] i_dat = '0;
  logic [1:0] i_mty = '0;
  logic       i_val = 1'b0;
  logic       i_eop = 1'b0;
  logic       i_rdy;
  logic [7:0] o_dat;
  logic [1:0] o_mty;
  logic       o_val;
  logic       o_eop;
  logic       o_rdy = 1'b1;
  logic [7:0] o_addr;
  logic [1:0] d_idx;
  logic [4:0] d_len;
  logic [1:0] d_mty;
  logic       d_err;
  logic       d_val;
  logic       d_rdy = 1'b1;
  logic       f_req = 1'b0;
  logic [2:0] used;

  int checks = 0;
  int errors = 0;

  // Writer-side log: {eop, mty, dat} per transferred word.
  logic [10:0] wq[$];

  ps_mm_buf_scheduler dut (
    .reset(reset), .clk(clk),
    .i_dat(i_dat), .i_mty(i_mty), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_mty(o_mty), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .o_addr(o_addr),
    .d_idx(d_idx), .d_len(d_len), .d_mty(d_mty), .d_err(d_err),
    .d_val(d_val), .d_rdy(d_rdy),
    .f_req(f_req), .used(used)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && o_val && o_rdy) wq.push_back({o_eop, o_mty, o_dat});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_val = 1'b0; i_eop = 1'b0; f_req = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    wq.delete();
  endtask

  // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] dat, input logic [1:0] mty, input logic eop);
    bit done = 1'b0;
    i_dat = dat; i_mty = mty; i_eop = eop; i_val = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (i_rdy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    i_val = 1'b0; i_eop = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] pat;
    int          w;
    bit          took;

    // ---- reset state ----
    #2;
    check("rst_used", used, 0);
    check("rst_dval", d_val, 0);
    check("rst_addr", o_addr, 0);
    check("rst_oval", o_val, 0);
    do_reset();
    check("rst_derr", d_err, 0);
    check("idle_rdy", i_rdy, 1);

    // ---- 1: 3-word packet, mty=1 ----
    d_rdy = 1'b0;
    check("t1_addr", o_addr, 0);
    send(8'h11, 2'd0, 1'b0);
    send(8'h12, 2'd0, 1'b0);
    check("t1_dval_early", d_val, 0);
    send(8'h13, 2'd1, 1'b1);
    check("t1_dval", d_val, 1);
    check("t1_idx", d_idx, 0);
    check("t1_len", d_len, 3);
    check("t1_mty", d_mty, 1);
    check("t1_err", d_err, 0);
    check("t1_used", used, 1);
    check("t1_wcnt", wq.size(), 3);
    if (wq.size() == 3) check("t1_last", wq[2], 11'h513);
    d_rdy = 1'b1;
    cyc();
    check("t1_dval_clr", d_val, 0);

    // ---- 2: five 1-word packets, ring fills and wraps ----
    do_reset();
    for (int p = 0; p < 4; p++) begin
      send(8'h20 + 8'(p), 2'd0, 1'b1);
      check("t2_idx", d_idx, p);
    end
    check("t2_used", used, 4);
    i_dat = 8'h24; i_eop = 1'b1; i_val = 1'b1;
    repeat (3) cyc();
    check("t2_full_rdy", i_rdy, 0);
    check("t2_wrap_addr", o_addr, 0);
    f_req = 1'b1;
    cyc();
    f_req = 1'b0;
    check("t2_used_rel", used, 3);
    send(8'h24, 2'd0, 1'b1);
    check("t2_wrap_idx", d_idx, 0);
    check("t2_used_end", used, 4);

    // ---- 3: 20-word packet truncated at 16 ----
    do_reset();
    d_rdy = 1'b0;
    for (int k = 1; k <= 20; k++)
      send(8'(k), (k == 20) ? 2'd2 : 2'd3, k == 20);
    check("t3_wcnt", wq.size(), 16);
    if (wq.size() == 16) begin
      check("t3_first", wq[0], 11'h301);
      check("t3_w15", wq[14], 11'h30f);
      check("t3_w16", wq[15], 11'h410);
    end
    check("t3_dval", d_val, 1);
    check("t3_len", d_len, 16);
    check("t3_err", d_err, 1);
    check("t3_mty", d_mty, 0);
    check("t3_idx", d_idx, 0);
    check("t3_closed", i_rdy, 0);
    d_rdy = 1'b1;
    cyc();

    // ---- 4: writer backpressure mid-packet ----
    do_reset();
    pat = 16'b1011_0010_1101_0110;
    w = 0;
    for (int c = 0; c < 100 && w < 6; c++) begin
      o_rdy = pat[c % 16];
      i_dat = 8'(w + 1); i_mty = 2'd0; i_eop = (w == 5); i_val = 1'b1;
      #1;
      check("t4_rdy", i_rdy, o_rdy);
      check("t4_addr", o_addr, 0);
      took = i_rdy;
      @(posedge clk);
      #1;
      if (took) w++;
    end
    i_val = 1'b0; i_eop = 1'b0; o_rdy = 1'b1;
    check("t4_done", w, 6);
    check("t4_wcnt", wq.size(), 6);
    for (int k = 0; k < wq.size() && k < 6; k++)
      check("t4_dat", wq[k], {(k == 5), 2'b00, 8'(k + 1)});
    check("t4_len", d_len, 6);

    // ---- 5: descriptor stall closes IDLE ----
    do_reset();
    d_rdy = 1'b0;
    send(8'h51, 2'd0, 1'b0);
    send(8'h52, 2'd3, 1'b1);
    i_dat = 8'h53; i_eop = 1'b1; i_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_stall_rdy", i_rdy, 0);
      check("t5_hold_len", d_len, 2);
      check("t5_hold_mty", d_mty, 3);
    end
    d_rdy = 1'b1;
    cyc();
    check("t5_dval_clr", d_val, 0);
    check("t5_open", i_rdy, 1);
    check("t5_addr", o_addr, 16);
    send(8'h53, 2'd0, 1'b1);
    check("t5_idx", d_idx, 1);

    // ---- 6: release corner cases and reset mid-packet ----
    do_reset();
    f_req = 1'b1;
    cyc();
    f_req = 1'b0;
    check("t6_rel_empty", used, 0);
    send(8'h61, 2'd0, 1'b1);
    send(8'h62, 2'd0, 1'b1);
    check("t6_used2", used, 2);
    i_dat = 8'h63; i_eop = 1'b1; i_val = 1'b1;
    cyc();
    #1;
    check("t6_pre_rdy", i_rdy, 1);
    f_req = 1'b1;
    cyc();
    f_req = 1'b0; i_val = 1'b0; i_eop = 1'b0;
    check("t6_coincide", used, 2);
    check("t6_idx", d_idx, 2);
    cyc();
    send(8'h64, 2'd0, 1'b0);
    send(8'h65, 2'd0, 1'b0);
    check("t6_addr_mid", o_addr, 48);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_addr", o_addr, 0);
    check("t6_rst_used", used, 0);
    check("t6_rst_dval", d_val, 0);
    check("t6_rst_oval", o_val, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_rst_nodesc", d_val, 0);
    send(8'h66, 2'd0, 1'b1);
    check("t6_after_idx", d_idx, 0);
    check("t6_after_len", d_len, 1);
    check("t6_after_used", used, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
